// File: rtl/episode_controller.sv
// Episode controller for a single grid-world Q-learning agent.
// Takes actions from the policy unit, drives the external state selector,
// range-guards its answer and hands (s, a, s', terminal) transitions to the
// Q-update unit, restarting episodes on goal or step limit until the run ends.
module episode_controller #(
  parameter int SW           = 6,
  parameter int N_STATES     = 25,
  parameter int START_STATE  = 1,
  parameter int GOAL_STATE   = 25,
  parameter int MAX_STEPS    = 64,
  parameter int MAX_EPISODES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          act_valid,
  input  logic [3:0]    act_action,
  output logic          act_ready,
  output logic [SW-1:0] sel_state,
  output logic [3:0]    sel_action,
  input  logic [SW-1:0] sel_next_state,
  output logic          upd_valid,
  input  logic          upd_ready,
  output logic [SW-1:0] upd_state,
  output logic [3:0]    upd_action,
  output logic [SW-1:0] upd_next_state,
  output logic          upd_terminal,
  output logic [SW-1:0] cur_state,
  output logic [6:0]    step_cnt,
  output logic [4:0]    episode_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACT,
    S_MOVE,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [SW-1:0] L_START  = SW'(START_STATE);
  localparam logic [SW-1:0] L_GOAL   = SW'(GOAL_STATE);
  localparam logic [SW-1:0] L_NMAX   = SW'(N_STATES);
  localparam logic [6:0]    L_MAXSTP = 7'(MAX_STEPS);
  localparam logic [4:0]    L_MAXEP  = 5'(MAX_EPISODES);

  state_t        r_state;
  logic [SW-1:0] r_cur_state;
  logic [6:0]    r_step_cnt;
  logic [4:0]    r_episode_cnt;
  logic [3:0]    r_sel_action;
  logic          r_act_ready;
  logic          r_upd_valid;
  logic [SW-1:0] r_upd_state;
  logic [3:0]    r_upd_action;
  logic [SW-1:0] r_upd_next_state;
  logic          r_upd_terminal;
  logic          r_busy;
  logic          r_done;

  logic [SW-1:0] w_ns;
  logic [6:0]    w_step_inc;
  logic [4:0]    w_ep_inc;

  // Guard the selector result: anything off the grid leaves the agent in place.
  always_comb begin
    w_ns = r_cur_state;
    if (sel_next_state != '0 && sel_next_state <= L_NMAX) begin
      w_ns = sel_next_state;
    end
  end

  assign w_step_inc = r_step_cnt + 7'd1;
  assign w_ep_inc   = r_episode_cnt + 5'd1;

  // Episode sequencing FSM; every output is a register updated on its transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cur_state      <= L_START;
      r_step_cnt       <= '0;
      r_episode_cnt    <= '0;
      r_sel_action     <= '0;
      r_act_ready      <= 1'b0;
      r_upd_valid      <= 1'b0;
      r_upd_state      <= '0;
      r_upd_action     <= '0;
      r_upd_next_state <= '0;
      r_upd_terminal   <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cur_state   <= L_START;
            r_step_cnt    <= '0;
            r_episode_cnt <= '0;
            r_act_ready   <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_state       <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT: begin
          if (act_valid) begin
            r_sel_action <= act_action;
            r_act_ready  <= 1'b0;
            r_state      <= S_MOVE;
          end
        end
        S_MOVE: begin
          // The selector has had a full cycle to settle on the registered action.
          r_upd_state      <= r_cur_state;
          r_upd_action     <= r_sel_action;
          r_upd_next_state <= w_ns;
          r_upd_terminal   <= (w_ns == L_GOAL) || (w_step_inc == L_MAXSTP);
          r_upd_valid      <= 1'b1;
          r_state          <= S_REPORT;
        end
        S_REPORT: begin
          if (upd_ready) begin
            r_upd_valid <= 1'b0;
            if (!r_upd_terminal) begin
              r_cur_state <= r_upd_next_state;
              r_step_cnt  <= w_step_inc;
              r_act_ready <= 1'b1;
              r_state     <= S_WAIT_ACT;
            end else begin
              r_episode_cnt <= w_ep_inc;
              if (w_ep_inc == L_MAXEP) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_cur_state <= L_START;
                r_step_cnt  <= '0;
                r_act_ready <= 1'b1;
                r_state     <= S_WAIT_ACT;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign act_ready      = r_act_ready;
  assign sel_state      = r_cur_state;
  assign sel_action     = r_sel_action;
  assign upd_valid      = r_upd_valid;
  assign upd_state      = r_upd_state;
  assign upd_action     = r_upd_action;
  assign upd_next_state = r_upd_next_state;
  assign upd_terminal   = r_upd_terminal;
  assign cur_state      = r_cur_state;
  assign step_cnt       = r_step_cnt;
  assign episode_cnt    = r_episode_cnt;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_episode_controller.sv
// Bench for episode_controller: two instances (default limits, and a short
// run with MAX_STEPS=4 / MAX_EPISODES=2) fed directed actions; expected
// transitions go into per-instance queues and a negedge monitor pops them.
module tb_episode_controller;

  typedef struct packed {
    logic [5:0] s;
    logic [3:0] a;
    logic [5:0] ns;
    logic       t;
  } tr_t;

  logic       clk;
  logic       rst_n;
  logic       start       [2];
  logic       act_valid   [2];
  logic [3:0] act_action  [2];
  logic       act_ready   [2];
  logic [5:0] sel_state   [2];
  logic [3:0] sel_action  [2];
  logic [5:0] sel_next    [2];
  logic       upd_valid   [2];
  logic       upd_ready   [2];
  logic [5:0] upd_state   [2];
  logic [3:0] upd_action  [2];
  logic [5:0] upd_ns      [2];
  logic       upd_term    [2];
  logic [5:0] cur_state   [2];
  logic [6:0] step_cnt    [2];
  logic [4:0] episode_cnt [2];
  logic       busy        [2];
  logic       done        [2];
  logic       force_en    [2];
  logic [5:0] force_val   [2];

  tr_t q0[$];
  tr_t q1[$];
  int  n_checks;
  int  n_fail;

  // Unclamped selector: moves off the grid produce out-of-range codes.
  function automatic logic [5:0] raw_sel(input logic [5:0] s, input logic [3:0] a);
    case (a)
      4'd0:    raw_sel = s + 6'd1;
      4'd1:    raw_sel = s - 6'd5;
      4'd2:    raw_sel = s - 6'd1;
      4'd3:    raw_sel = s + 6'd5;
      default: raw_sel = s;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    episode_controller #(
      .MAX_STEPS   ((g == 0) ? 64 : 4),
      .MAX_EPISODES((g == 0) ? 16 : 2)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start[g]),
      .act_valid     (act_valid[g]),
      .act_action    (act_action[g]),
      .act_ready     (act_ready[g]),
      .sel_state     (sel_state[g]),
      .sel_action    (sel_action[g]),
      .sel_next_state(sel_next[g]),
      .upd_valid     (upd_valid[g]),
      .upd_ready     (upd_ready[g]),
      .upd_state     (upd_state[g]),
      .upd_action    (upd_action[g]),
      .upd_next_state(upd_ns[g]),
      .upd_terminal  (upd_term[g]),
      .cur_state     (cur_state[g]),
      .step_cnt      (step_cnt[g]),
      .episode_cnt   (episode_cnt[g]),
      .busy          (busy[g]),
      .done          (done[g])
    );
    assign sel_next[g] = force_en[g] ? force_val[g] : raw_sel(sel_state[g], sel_action[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    qsize = (d == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: every accepted transition is checked against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (upd_valid[d] === 1'b1 && upd_ready[d] === 1'b1) begin
        if (qsize(d) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_transition dut%0d: got s=%0d a=%0d ns=%0d t=%0b, none expected",
                   d, upd_state[d], upd_action[d], upd_ns[d], upd_term[d]);
        end else begin
          tr_t e;
          tr_t got;
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          got = '{s: upd_state[d], a: upd_action[d], ns: upd_ns[d], t: upd_term[d]};
          n_checks++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL transition dut%0d: got s=%0d a=%0d ns=%0d t=%0b expected s=%0d a=%0d ns=%0d t=%0b",
                     d, got.s, got.a, got.ns, got.t, e.s, e.a, e.ns, e.t);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  // One agent step: handshake an action, check latency, optionally stall REPORT.
  task automatic do_step(input int d, input logic [3:0] a, input logic [5:0] s,
                         input logic [5:0] ns, input logic t, input int stall);
    int   k;
    tr_t  e;
    logic [16:0] snap;
    k = 0;
    while (act_ready[d] !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("act_ready_wait", d, act_ready[d], 1);
    e = '{s: s, a: a, ns: ns, t: t};
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (stall > 0) upd_ready[d] = 1'b0;
    act_valid[d]  = 1'b1;
    act_action[d] = a;
    tick();
    act_valid[d] = 1'b0;
    chk("lat_move_valid", d, upd_valid[d], 0);
    tick();
    chk("lat_report_valid", d, upd_valid[d], 1);
    snap = {upd_state[d], upd_action[d], upd_ns[d], upd_term[d]};
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", d, upd_valid[d], 1);
      chk("stall_hold", d, {upd_state[d], upd_action[d], upd_ns[d], upd_term[d]}, snap);
      chk("stall_act_ready", d, act_ready[d], 0);
      if (i == 0) begin
        act_valid[d]  = 1'b1;
        act_action[d] = a + 4'd1;
      end
      if (i == 1) start[d] = 1'b1;
      if (i == 2) start[d] = 1'b0;
      if (i == stall - 1) begin
        act_valid[d] = 1'b0;
        upd_ready[d] = 1'b1;
      end
      tick();
    end
    k = 0;
    while (qsize(d) != 0 && k < 20) begin
      tick();
      k++;
    end
    chk("drain", d, qsize(d), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d]      = 1'b0;
      act_valid[d]  = 1'b0;
      act_action[d] = 4'd0;
      upd_ready[d]  = 1'b1;
      force_en[d]   = 1'b0;
      force_val[d]  = 6'd0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_cur_state", d, cur_state[d], 1);
      chk("rst_step_cnt", d, step_cnt[d], 0);
      chk("rst_episode_cnt", d, episode_cnt[d], 0);
      chk("rst_act_ready", d, act_ready[d], 0);
      chk("rst_upd_valid", d, upd_valid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_done", d, done[d], 0);
      chk("rst_upd_fields", d, {upd_state[d], upd_action[d], upd_ns[d], upd_term[d], sel_action[d]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // Four rights from the start state.
    pulse_start(0);
    chk("start_busy", 0, busy[0], 1);
    chk("start_act_ready", 0, act_ready[0], 1);
    do_step(0, 4'd0, 6'd1, 6'd2, 1'b0, 0);
    do_step(0, 4'd0, 6'd2, 6'd3, 1'b0, 0);
    do_step(0, 4'd0, 6'd3, 6'd4, 1'b0, 0);
    do_step(0, 4'd0, 6'd4, 6'd5, 1'b0, 0);
    chk("t1_step_cnt", 0, step_cnt[0], 4);
    chk("t1_cur_state", 0, cur_state[0], 5);

    // Four downs to the goal.
    do_step(0, 4'd3, 6'd5,  6'd10, 1'b0, 0);
    do_step(0, 4'd3, 6'd10, 6'd15, 1'b0, 0);
    do_step(0, 4'd3, 6'd15, 6'd20, 1'b0, 0);
    do_step(0, 4'd3, 6'd20, 6'd25, 1'b1, 0);
    chk("t2_episode_cnt", 0, episode_cnt[0], 1);
    chk("t2_cur_state", 0, cur_state[0], 1);
    chk("t2_step_cnt", 0, step_cnt[0], 0);

    // Out-of-range selector answers (26 and 0) and a stay action.
    do_step(0, 4'd3, 6'd1,  6'd6,  1'b0, 0);
    do_step(0, 4'd3, 6'd6,  6'd11, 1'b0, 0);
    do_step(0, 4'd3, 6'd11, 6'd16, 1'b0, 0);
    do_step(0, 4'd3, 6'd16, 6'd21, 1'b0, 0);
    do_step(0, 4'd3, 6'd21, 6'd21, 1'b0, 0);
    force_en[0]  = 1'b1;
    force_val[0] = 6'd0;
    do_step(0, 4'd1, 6'd21, 6'd21, 1'b0, 0);
    force_en[0] = 1'b0;
    do_step(0, 4'd7, 6'd21, 6'd21, 1'b0, 0);
    chk("t3_step_cnt", 0, step_cnt[0], 7);
    chk("t3_cur_state", 0, cur_state[0], 21);

    // Five-cycle stall in REPORT with stray act_valid and start.
    do_step(0, 4'd0, 6'd21, 6'd22, 1'b0, 5);
    chk("t5_step_cnt", 0, step_cnt[0], 8);
    chk("t5_cur_state", 0, cur_state[0], 22);
    chk("t5_episode_cnt", 0, episode_cnt[0], 1);
    do_step(0, 4'd0, 6'd22, 6'd23, 1'b0, 0);
    do_step(0, 4'd0, 6'd23, 6'd24, 1'b0, 0);
    do_step(0, 4'd0, 6'd24, 6'd25, 1'b1, 0);
    chk("t5_episode_cnt_end", 0, episode_cnt[0], 2);
    chk("t5_busy", 0, busy[0], 1);
    chk("t5_done", 0, done[0], 0);

    // Step limit of 4 with repeated left at state 1.
    pulse_start(1);
    do_step(1, 4'd2, 6'd1, 6'd1, 1'b0, 0);
    do_step(1, 4'd2, 6'd1, 6'd1, 1'b0, 0);
    do_step(1, 4'd2, 6'd1, 6'd1, 1'b0, 0);
    do_step(1, 4'd2, 6'd1, 6'd1, 1'b1, 0);
    chk("t4_episode_cnt", 1, episode_cnt[1], 1);
    chk("t4_cur_state", 1, cur_state[1], 1);
    chk("t4_step_cnt", 1, step_cnt[1], 0);

    // Goal on the step-limit step ends the run.
    do_step(1, 4'd5, 6'd1, 6'd1, 1'b0, 0);
    do_step(1, 4'd5, 6'd1, 6'd1, 1'b0, 0);
    do_step(1, 4'd5, 6'd1, 6'd1, 1'b0, 0);
    force_en[1]  = 1'b1;
    force_val[1] = 6'd25;
    do_step(1, 4'd0, 6'd1, 6'd25, 1'b1, 0);
    force_en[1] = 1'b0;
    chk("t6_done", 1, done[1], 1);
    chk("t6_busy", 1, busy[1], 0);
    chk("t6_episode_cnt", 1, episode_cnt[1], 2);
    chk("t6_step_cnt", 1, step_cnt[1], 3);
    chk("t6_cur_state", 1, cur_state[1], 1);
    act_valid[1] = 1'b1;
    tick();
    act_valid[1] = 1'b0;
    chk("t6_act_ignored_ready", 1, act_ready[1], 0);
    chk("t6_act_ignored_done", 1, done[1], 1);

    pulse_start(1);
    chk("t6_restart_busy", 1, busy[1], 1);
    chk("t6_restart_done", 1, done[1], 0);
    chk("t6_restart_episode_cnt", 1, episode_cnt[1], 0);
    chk("t6_restart_step_cnt", 1, step_cnt[1], 0);
    chk("t6_restart_cur_state", 1, cur_state[1], 1);

    // Reset while a transition is waiting in REPORT.
    upd_ready[1]  = 1'b0;
    act_valid[1]  = 1'b1;
    act_action[1] = 4'd0;
    tick();
    act_valid[1] = 1'b0;
    tick();
    chk("rst_mid_pre_valid", 1, upd_valid[1], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_upd_valid", 1, upd_valid[1], 0);
    chk("rst_mid_busy", 1, busy[1], 0);
    chk("rst_mid_act_ready", 1, act_ready[1], 0);
    chk("rst_mid_upd_state", 1, upd_state[1], 0);
    chk("rst_mid_cur_state", 1, cur_state[1], 1);
    tick();
    rst_n        = 1'b1;
    upd_ready[1] = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle_valid", 1, upd_valid[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
